// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: core (M0) priority, loader (M1) bounded lock bursts, registered read return.
// Optional M1 starvation guard enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
    parameter int          WAIT_MAX = 8,
    parameter int          LOCK_MAX = 16,
    parameter logic [31:0] RAM_TOP  = 32'h0000_00FC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_wd,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_wd,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic        m1_err,
    output logic [31:0] m1_rd,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic [1:0]  dbg_state
);

    // Handshake: a master holds req (with stable address/data) until gnt is seen in the
    // same cycle; dropping req before gnt withdraws it. Read data follows one cycle later
    // with rvalid, and rd holds until that master's next read.
    typedef enum logic [1:0] {ARB = 2'd0, LOCK1 = 2'd1, FORCE0 = 2'd2} state_t;

    localparam int LW = $clog2(LOCK_MAX + 1);

    state_t        state, state_nx;
    logic [LW-1:0] lock_cnt, lock_cnt_nx;
    logic          starve;
    logic          m1_addr_ok;
    logic          m1_fwd;

    assign m1_addr_ok = (m1_a <= RAM_TOP) && (m1_a[1:0] == 2'b00);
    assign m1_fwd     = m1_gnt && m1_addr_ok;
    assign dbg_state  = state;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int WW = $clog2(WAIT_MAX + 1);
    logic [WW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!reset)
            wait_cnt <= '0;
        else if (m1_gnt)
            wait_cnt <= '0;
        else if (m1_req && (wait_cnt != WW'(WAIT_MAX)))
            wait_cnt <= wait_cnt + WW'(1);
    end

    assign starve = m1_req && (wait_cnt == WW'(WAIT_MAX));
`else
    // Without the counter the only case left is a zero wait limit, where M1 never waits.
    assign starve = m1_req && (WAIT_MAX == 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ARB;
            lock_cnt <= '0;
        end else begin
            state    <= state_nx;
            lock_cnt <= lock_cnt_nx;
        end
    end

    // lock_cnt counts M1 grants in the current locked burst, including the entry grant.
    always_comb begin
        state_nx    = state;
        lock_cnt_nx = lock_cnt;
        case (state)
            ARB: begin
                lock_cnt_nx = '0;
                if (m1_gnt && m1_lock) begin
                    lock_cnt_nx = LW'(1);
                    state_nx    = (LOCK_MAX <= 1) ? FORCE0 : LOCK1;
                end
            end
            LOCK1: begin
                if (!m1_req || !m1_lock) begin
                    state_nx    = ARB;
                    lock_cnt_nx = '0;
                end else if ((lock_cnt + LW'(1)) >= LW'(LOCK_MAX)) begin
                    state_nx    = FORCE0;
                    lock_cnt_nx = '0;
                end else begin
                    lock_cnt_nx = lock_cnt + LW'(1);
                end
            end
            FORCE0: begin
                state_nx    = ARB;
                lock_cnt_nx = '0;
            end
            default: begin
                state_nx    = ARB;
                lock_cnt_nx = '0;
            end
        endcase
    end

    // Grants are combinational; a rejected M1 address still takes the slot but never reaches memory.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (reset) begin
            case (state)
                ARB: begin
                    if (m0_req && !starve)
                        m0_gnt = 1'b1;
                    else if (m1_req)
                        m1_gnt = 1'b1;
                end
                LOCK1:   m1_gnt = m1_req;
                FORCE0:  m0_gnt = m0_req;
                default: begin
                    m0_gnt = 1'b0;
                    m1_gnt = 1'b0;
                end
            endcase
        end
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (m0_gnt) begin
            mem_we = m0_we;
            mem_a  = m0_a;
            mem_wd = m0_wd;
        end else if (m1_fwd) begin
            mem_we = m1_we;
            mem_a  = m1_a;
            mem_wd = m1_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_err    <= 1'b0;
            m0_rd     <= '0;
            m1_rd     <= '0;
        end else begin
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_fwd && !m1_we;
            m1_err    <= m1_gnt && !m1_addr_ok;
            if (m0_gnt && !m0_we)
                m0_rd <= mem_rd;
            if (m1_fwd && !m1_we)
                m1_rd <= mem_rd;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a memory/peripheral model and queue-based read/error scoreboard.
module tb_dmem_arbiter;
    localparam int WAIT_MAX = 8;
    localparam int LOCK_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_a, m0_wd, m1_a, m1_wd;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [1:0]  dbg_state;

    logic [31:0] ram [0:63];
    logic [31:0] leds;
    logic [31:0] sw = 32'h0000_05A5;

    logic [31:0] exp_m0_q[$];
    logic [31:0] exp_m1_q[$];
    logic [31:0] exp_err_q[$];
    int checks = 0;
    int errors = 0;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    bit starve_guard = 1'b1;
`else
    bit starve_guard = 1'b0;
`endif

    dmem_arbiter #(.WAIT_MAX(WAIT_MAX), .LOCK_MAX(LOCK_MAX), .RAM_TOP(32'h0000_00FC)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_a(m0_a), .m0_wd(m0_wd),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_a(m1_a), .m1_wd(m1_wd),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rd(m1_rd),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .dbg_state(dbg_state)
    );

    // Clock / memory model: RAM words at 0x00-0xFC, switches at 0xC000_0000, LEDs at 0xC000_0004.
    always #5 clk = ~clk;

    always_comb begin
        if (mem_a == 32'hC000_0000)
            mem_rd = sw;
        else if (mem_a == 32'hC000_0004)
            mem_rd = leds;
        else
            mem_rd = ram[mem_a[7:2]];
    end

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++)
                ram[i] <= (i == 4) ? 32'h0000_AAAA : (i == 8) ? 32'h0000_BBBB : 32'h0;
            leds <= 32'h0;
        end else if (mem_we) begin
            if (mem_a == 32'hC000_0004)
                leds <= mem_wd;
            else if (mem_a[31:8] == 24'h0)
                ram[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents read data or an error pulse.
    always @(negedge clk) begin
        if (m0_rvalid) begin
            if (exp_m0_q.size() == 0) chk("m0_rvalid_unexpected", {31'b0, m0_rvalid}, 32'h0);
            else chk("m0_rd", m0_rd, exp_m0_q.pop_front());
        end
        if (m1_rvalid) begin
            if (exp_m1_q.size() == 0) chk("m1_rvalid_unexpected", {31'b0, m1_rvalid}, 32'h0);
            else chk("m1_rd", m1_rd, exp_m1_q.pop_front());
        end
        if (m1_err) begin
            if (exp_err_q.size() == 0) chk("m1_err_unexpected", {31'b0, m1_err}, 32'h0);
            else chk("m1_err_rvalid", {31'b0, m1_rvalid}, exp_err_q.pop_front());
        end
    end

    task automatic m0_drive(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
        m0_req = req; m0_we = we; m0_a = a; m0_wd = wd;
    endtask

    task automatic m1_drive(input logic req, input logic we, input logic lock,
                            input logic [31:0] a, input logic [31:0] wd);
        m1_req = req; m1_we = we; m1_lock = lock; m1_a = a; m1_wd = wd;
    endtask

    // One cycle: check grants and the memory port mid-cycle, then advance past the next edge.
    task automatic cyc(input string tag, input logic e0, input logic e1,
                       input logic e_we, input logic [31:0] e_a);
        @(negedge clk);
        chk({tag, ".m0_gnt"}, {31'b0, m0_gnt}, {31'b0, e0});
        chk({tag, ".m1_gnt"}, {31'b0, m1_gnt}, {31'b0, e1});
        chk({tag, ".mem_we"}, {31'b0, mem_we}, {31'b0, e_we});
        if (e0 || e_we)
            chk({tag, ".mem_a"}, mem_a, e_a);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        m0_drive(1'b1, 1'b0, 32'h10, 32'h0);
        m1_drive(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);

        // Reset held with both masters requesting.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst.m0_gnt", {31'b0, m0_gnt}, 32'h0);
            chk("rst.m1_gnt", {31'b0, m1_gnt}, 32'h0);
            chk("rst.mem_we", {31'b0, mem_we}, 32'h0);
            chk("rst.m0_rvalid", {31'b0, m0_rvalid}, 32'h0);
            chk("rst.m1_rvalid", {31'b0, m1_rvalid}, 32'h0);
            chk("rst.m1_err", {31'b0, m1_err}, 32'h0);
            chk("rst.m0_rd", m0_rd, 32'h0);
            chk("rst.m1_rd", m1_rd, 32'h0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Simultaneous reads: M0 first, M1 the cycle after.
        exp_m0_q.push_back(32'h0000_AAAA);
        cyc("sim_c0", 1'b1, 1'b0, 1'b0, 32'h10);
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0);
        exp_m1_q.push_back(32'h0000_BBBB);
        cyc("sim_c1", 1'b0, 1'b1, 1'b0, 32'h0);
        m1_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc("sim_c2", 1'b0, 1'b0, 1'b0, 32'h0);
        chk("m0_rd_hold", m0_rd, 32'h0000_AAAA);

        // Locked burst: four grants, forced M0 slot, then re-entry only through arbitration.
        m1_drive(1'b1, 1'b1, 1'b1, 32'h00, 32'h100);
        cyc("lk_a0", 1'b0, 1'b1, 1'b1, 32'h00);
        m0_drive(1'b1, 1'b0, 32'h10, 32'h0);
        for (int i = 1; i < 4; i++) begin
            m1_drive(1'b1, 1'b1, 1'b1, 32'(4 * i), 32'(32'h100 + 4 * i));
            cyc("lk_a", 1'b0, 1'b1, 1'b1, 32'(4 * i));
        end
        m1_drive(1'b1, 1'b1, 1'b1, 32'h10, 32'h110);
        exp_m0_q.push_back(32'h0000_AAAA);
        cyc("lk_force", 1'b1, 1'b0, 1'b0, 32'h10);
        m0_drive(1'b1, 1'b0, 32'h20, 32'h0);
        exp_m0_q.push_back(32'h0000_BBBB);
        cyc("lk_arb_m0", 1'b1, 1'b0, 1'b0, 32'h20);
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0);
        cyc("lk_b0", 1'b0, 1'b1, 1'b1, 32'h10);
        for (int i = 5; i < 8; i++) begin
            m1_drive(1'b1, 1'b1, 1'b1, 32'(4 * i), 32'(32'h100 + 4 * i));
            cyc("lk_b", 1'b0, 1'b1, 1'b1, 32'(4 * i));
        end
        m1_drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h140);
        cyc("lk_force_idle", 1'b0, 1'b0, 1'b0, 32'h0);
        cyc("lk_after", 1'b0, 1'b1, 1'b1, 32'h40);
        m1_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Read back burst data through M0.
        m0_drive(1'b1, 1'b0, 32'h10, 32'h0);
        exp_m0_q.push_back(32'h110);
        cyc("rb_10", 1'b1, 1'b0, 1'b0, 32'h10);
        m0_drive(1'b1, 1'b0, 32'h1C, 32'h0);
        exp_m0_q.push_back(32'h11C);
        cyc("rb_1c", 1'b1, 1'b0, 1'b0, 32'h1C);
        m0_drive(1'b1, 1'b0, 32'h40, 32'h0);
        exp_m0_q.push_back(32'h140);
        cyc("rb_40", 1'b1, 1'b0, 1'b0, 32'h40);
        m0_drive(1'b1, 1'b0, 32'h00, 32'h0);
        exp_m0_q.push_back(32'h100);
        cyc("rb_00", 1'b1, 1'b0, 1'b0, 32'h00);
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0);
        cyc("rb_idle", 1'b0, 1'b0, 1'b0, 32'h0);

        // Continuous contention: guard grants M1 on cycle 8, otherwise M1 starves.
        m0_drive(1'b1, 1'b0, 32'h10, 32'h0);
        m1_drive(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        for (int k = 0; k < 100; k++) begin
            logic e1;
            e1 = starve_guard && (k == 8);
            if (starve_guard && k > 8)
                m1_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (e1) exp_m1_q.push_back(32'h0000_BBBB);
            else    exp_m0_q.push_back(32'h110);
            cyc("starve", !e1, e1, 1'b0, 32'h10);
        end
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0);
        m1_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc("starve_end", 1'b0, 1'b0, 1'b0, 32'h0);

        // M1 address errors: LED write, misaligned, out of range.
        m1_drive(1'b1, 1'b1, 1'b0, 32'hC000_0004, 32'h3FF);
        exp_err_q.push_back(32'h0);
        cyc("err_led", 1'b0, 1'b1, 1'b0, 32'h0);
        m1_drive(1'b1, 1'b0, 1'b0, 32'h22, 32'h0);
        exp_err_q.push_back(32'h0);
        cyc("err_misal", 1'b0, 1'b1, 1'b0, 32'h0);
        m1_drive(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        exp_err_q.push_back(32'h0);
        cyc("err_range", 1'b0, 1'b1, 1'b0, 32'h0);
        m1_drive(1'b1, 1'b1, 1'b0, 32'hFC, 32'h000F_C0FC);
        cyc("top_wr", 1'b0, 1'b1, 1'b1, 32'hFC);
        m1_drive(1'b1, 1'b0, 1'b0, 32'hFC, 32'h0);
        exp_m1_q.push_back(32'h000F_C0FC);
        cyc("top_rd", 1'b0, 1'b1, 1'b0, 32'h0);
        m1_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc("err_idle", 1'b0, 1'b0, 1'b0, 32'h0);
        chk("leds_unchanged", leds, 32'h0);

        // M0 peripheral pass-through.
        m0_drive(1'b1, 1'b1, 32'hC000_0004, 32'h3FF);
        cyc("pt_wr", 1'b1, 1'b0, 1'b1, 32'hC000_0004);
        chk("leds_written", leds, 32'h3FF);
        m0_drive(1'b1, 1'b0, 32'hC000_0000, 32'h0);
        exp_m0_q.push_back(32'h0000_05A5);
        cyc("pt_rd", 1'b1, 1'b0, 1'b0, 32'hC000_0000);
        m0_drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++)
            cyc("drain", 1'b0, 1'b0, 1'b0, 32'h0);

        chk("m0_q_left", 32'(exp_m0_q.size()), 32'h0);
        chk("m1_q_left", 32'(exp_m1_q.size()), 32'h0);
        chk("err_q_left", 32'(exp_err_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
